// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, flag indices and FSM encoding.
package fp32_pkg;

    localparam int unsigned SIGN_W  = 1;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MANT_W  = 23;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [31:0] FP_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // prod_flags = {over, under, zero, done}
    localparam int unsigned PF_OVER  = 3;
    localparam int unsigned PF_UNDER = 2;
    localparam int unsigned PF_ZERO  = 1;
    localparam int unsigned PF_DONE  = 0;

    // acc_flags = {over, under, zero}
    localparam int unsigned AF_OVER  = 2;
    localparam int unsigned AF_UNDER = 1;
    localparam int unsigned AF_ZERO  = 0;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StAlign = 3'd1,
        StAdd   = 3'd2,
        StNorm  = 3'd3,
        StPack  = 3'd4
    } state_e;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero count of a 27-bit significand; all-zero input returns 27.
module fp_lzc (
    input  logic [26:0] val_i,
    output logic [4:0]  cnt_o
);

    // Scan LSB to MSB so the highest set bit makes the last assignment.
    always_comb begin
        cnt_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (val_i[i]) begin
                cnt_o = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fp_accumulator.sv
// Multi-cycle single-precision accumulator: IDLE -> ALIGN -> ADD -> NORM -> PACK.
// Truncating rounding, zero/denormal operands flushed to +0, sticky overflow.
module fp_accumulator
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [31:0] prod_in,
    input  logic [3:0]  prod_flags,
    output logic [31:0] acc_out,
    output logic        acc_done,
    output logic [2:0]  acc_flags,
    output logic        busy,
    output logic        drop_err
);

    state_e             state_q, state_d;
    logic [31:0]        prod_q, prod_d;
    logic               pover_q, pover_d;     // product flagged over
    logic               pzero_q, pzero_d;     // product flagged under or zero
    logic               sign_q, sign_d;       // sign of the larger-magnitude operand
    logic               eff_sub_q, eff_sub_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [25:0]        big_q, big_d;         // 24-bit significand + 2 guard bits
    logic [25:0]        small_q, small_d;
    logic [26:0]        sum_q, sum_d;         // bit 26 is the carry-out
    logic [MANT_W-1:0]  mant_q, mant_d;
    logic signed [9:0]  nexp_q, nexp_d;
    logic               zero_q, zero_d;
    logic [31:0]        acc_q, acc_d;
    logic               done_q, done_d;
    logic [2:0]         flags_q, flags_d;
    logic               drop_q, drop_d;

    logic [31:0]        op_a, op_b, op_big, op_small;
    logic [EXP_W-1:0]   ediff;
    logic [25:0]        small_ext, small_sh;
    logic [4:0]         lz;
    logic [26:0]        shifted;
    logic [3:0]         unused_shift;

    fp_lzc u_lzc (
        .val_i (sum_q),
        .cnt_o (lz)
    );

    // Operand flush-to-zero, magnitude swap and right-shift alignment of the smaller operand.
    always_comb begin
        op_a = (acc_q[30:23] == '0) ? FP_ZERO : acc_q;
        op_b = (prod_q[30:23] == '0 || pzero_q) ? FP_ZERO : prod_q;
        if (op_b[30:0] > op_a[30:0]) begin
            op_big   = op_b;
            op_small = op_a;
        end else begin
            op_big   = op_a;
            op_small = op_b;
        end
        ediff     = op_big[30:23] - op_small[30:23];
        small_ext = {|op_small[30:23], op_small[22:0], 2'b00};
        small_sh  = (ediff >= 8'd26) ? '0 : (small_ext >> ediff);
    end

    // Normalise so the leading one lands in bit 26; lz == 0 (carry-out) acts as a right
    // shift by one with exponent +1, otherwise a left shift with exponent reduced.
    always_comb begin
        shifted      = sum_q << lz;
        unused_shift = {shifted[26], shifted[2:0]};
    end

    // Next-state for the FSM, datapath pipeline registers and sticky status.
    always_comb begin
        state_d   = state_q;
        prod_d    = prod_q;
        pover_d   = pover_q;
        pzero_d   = pzero_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        big_d     = big_q;
        small_d   = small_q;
        sum_d     = sum_q;
        mant_d    = mant_q;
        nexp_d    = nexp_q;
        zero_d    = zero_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        flags_d   = flags_q;
        drop_d    = drop_q;

        if (clear) begin
            state_d = StIdle;
            acc_d   = FP_ZERO;
            flags_d = '0;
            drop_d  = 1'b0;
        end else begin
            if (prod_flags[PF_DONE] && state_q != StIdle) begin
                drop_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (prod_flags[PF_DONE]) begin
                        prod_d  = prod_in;
                        pover_d = prod_flags[PF_OVER];
                        pzero_d = prod_flags[PF_UNDER] | prod_flags[PF_ZERO];
                        state_d = StAlign;
                    end
                end
                StAlign: begin
                    sign_d    = op_big[31];
                    eff_sub_d = op_big[31] ^ op_small[31];
                    exp_d     = op_big[30:23];
                    big_d     = {|op_big[30:23], op_big[22:0], 2'b00};
                    small_d   = small_sh;
                    state_d   = StAdd;
                end
                StAdd: begin
                    sum_d   = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                                        : ({1'b0, big_q} + {1'b0, small_q});
                    state_d = StNorm;
                end
                StNorm: begin
                    zero_d  = (sum_q == '0);
                    mant_d  = shifted[25:3];  // guard bits [2:1] dropped: truncation
                    nexp_d  = $signed({2'b00, exp_q} + 10'd1 - {5'd0, lz});
                    state_d = StPack;
                end
                StPack: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (flags_q[AF_OVER]) begin
                        acc_d = acc_q;  // overflow holds infinity until clear
                    end else if (pover_q) begin
                        acc_d             = {prod_q[31], FP_INF[30:0]};
                        flags_d[AF_OVER]  = 1'b1;
                        flags_d[AF_ZERO]  = 1'b0;
                    end else if (zero_q) begin
                        acc_d             = FP_ZERO;
                        flags_d[AF_ZERO]  = 1'b1;
                    end else if (nexp_q >= $signed(10'(EXP_MAX))) begin
                        acc_d             = {sign_q, FP_INF[30:0]};
                        flags_d[AF_OVER]  = 1'b1;
                        flags_d[AF_ZERO]  = 1'b0;
                    end else if (nexp_q <= 10'sd0) begin
                        acc_d             = FP_ZERO;
                        flags_d[AF_UNDER] = 1'b1;
                    end else begin
                        acc_d             = {sign_q, nexp_q[7:0], mant_q};
                        flags_d[AF_ZERO]  = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // All state, asynchronously reset to zero / IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            prod_q    <= '0;
            pover_q   <= 1'b0;
            pzero_q   <= 1'b0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            small_q   <= '0;
            sum_q     <= '0;
            mant_q    <= '0;
            nexp_q    <= '0;
            zero_q    <= 1'b0;
            acc_q     <= FP_ZERO;
            done_q    <= 1'b0;
            flags_q   <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prod_q    <= prod_d;
            pover_q   <= pover_d;
            pzero_q   <= pzero_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_q     <= exp_d;
            big_q     <= big_d;
            small_q   <= small_d;
            sum_q     <= sum_d;
            mant_q    <= mant_d;
            nexp_q    <= nexp_d;
            zero_q    <= zero_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            flags_q   <= flags_d;
            drop_q    <= drop_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_done  = done_q;
    assign acc_flags = flags_q;
    assign busy      = (state_q != StIdle);
    assign drop_err  = drop_q;

endmodule
